pim_cmd_arbiter: RTL

Shares one PIM controller command port between NUM_REQ sequencer instances.
- Each requester presents a valid/ready micro-op command. The arbiter grants one requester at a time in round-robin order and forwards its command.
- After forwarding, it holds ownership until the PIM controller's one-cycle pim_op_done pulse. It routes that pulse back to the owning requester only.
- A watchdog aborts ownership if done never arrives, so a hung op cannot lock out other requesters.

---
 rtl/pim_cmd_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pim_cmd_arbiter.sv
// Round-robin arbiter sharing one PIM controller command port between NUM_REQ sequencers,
// with done routing and a watchdog. Define PIM_ARB_STATS_EN for per-requester accept counters.
module pim_cmd_arbiter #(
  parameter int unsigned NUM_REQ             = 4,
  parameter int unsigned CMD_SIZE_BITS       = 64,
  parameter int unsigned DONE_TIMEOUT_CYCLES = 1024,
  parameter int unsigned STAT_W              = 16,
  localparam int unsigned IdW                = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*CMD_SIZE_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               req_done,
  output logic                             pim_cmd_valid,
  output logic [CMD_SIZE_BITS-1:0]         pim_cmd_data,
  input  logic                             pim_cmd_ready,
  input  logic                             pim_op_done,
  output logic [IdW-1:0]                   owner_id,
  output logic                             arb_busy,
  output logic                             timeout_err,
  output logic [IdW-1:0]                   timeout_id,
  input  logic                             timeout_clr
`ifdef PIM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]        stat_count,
  input  logic                             stat_clr
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..16");
  end
  if (DONE_TIMEOUT_CYCLES < 2 || DONE_TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("DONE_TIMEOUT_CYCLES must be in 2..65535");
  end
  if (STAT_W < 1) begin : g_bad_stat_w
    $error("STAT_W must be at least 1");
  end

  typedef enum logic [1:0] {StArb, StIssue, StWaitDone} state_e;

  state_e                                state_q, state_d;
  logic [IdW-1:0]                        owner_id_q, owner_id_d;
  logic [IdW-1:0]                        last_grant_q, last_grant_d;
  logic [15:0]                           wdog_q, wdog_d;
  logic                                  timeout_err_q, timeout_err_d;
  logic [IdW-1:0]                        timeout_id_q, timeout_id_d;
  logic                                  accept;
  logic                                  timeout_fire;
  logic [NUM_REQ-1:0][CMD_SIZE_BITS-1:0] req_data_arr;

  // Round-robin search state
  logic                                  found;
  logic [IdW-1:0]                        winner;
  logic [IdW-1:0]                        cand;
  int unsigned                           arb_idx;

  assign req_data_arr = req_data;

  // Search starts one past the last accepted requester so it gets lowest priority next.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    cand    = '0;
    arb_idx = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      arb_idx = (32'(last_grant_q) + k) % NUM_REQ;
      cand    = IdW'(arb_idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_id_d    = owner_id_q;
    last_grant_d  = last_grant_q;
    wdog_d        = wdog_q;
    accept        = 1'b0;
    timeout_fire  = 1'b0;
    req_ready     = '0;
    req_done      = '0;
    pim_cmd_valid = 1'b0;
    pim_cmd_data  = '0;
    case (state_q)
      StArb: begin
        if (found) begin
          owner_id_d = winner;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        pim_cmd_valid         = req_valid[owner_id_q];
        pim_cmd_data          = req_data_arr[owner_id_q];
        req_ready[owner_id_q] = pim_cmd_ready;
        if (!req_valid[owner_id_q]) begin
          state_d = StArb;
        end else if (pim_cmd_ready) begin
          accept       = 1'b1;
          last_grant_d = owner_id_q;
          wdog_d       = 16'(DONE_TIMEOUT_CYCLES);
          state_d      = StWaitDone;
        end
      end
      StWaitDone: begin
        if (pim_op_done) begin
          req_done[owner_id_q] = 1'b1;
          state_d              = StArb;
        end else begin
          wdog_d = wdog_q - 16'd1;
          if (wdog_q == 16'd1) begin
            timeout_fire = 1'b1;
            state_d      = StArb;
          end
        end
      end
      default: state_d = StArb;
    endcase
  end

  // A timeout coinciding with a clear still sets the flag.
  always_comb begin
    timeout_err_d = timeout_err_q;
    timeout_id_d  = timeout_id_q;
    if (timeout_clr) timeout_err_d = 1'b0;
    if (timeout_fire) begin
      timeout_err_d = 1'b1;
      if (!timeout_err_q) timeout_id_d = owner_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StArb;
      owner_id_q    <= '0;
      last_grant_q  <= IdW'(NUM_REQ - 1);
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
    end else begin
      state_q       <= state_d;
      owner_id_q    <= owner_id_d;
      last_grant_q  <= last_grant_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
      timeout_id_q  <= timeout_id_d;
    end
  end

  assign owner_id    = owner_id_q;
  assign arb_busy    = (state_q != StArb);
  assign timeout_err = timeout_err_q;
  assign timeout_id  = timeout_id_q;

`ifdef PIM_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] stat_q, stat_d;

  // Clear takes priority over a coincident increment; counters saturate at all-ones.
  always_comb begin
    stat_d = stat_q;
    if (stat_clr) begin
      stat_d = '0;
    end else if (accept && (stat_q[owner_id_q] != '1)) begin
      stat_d[owner_id_q] = stat_q[owner_id_q] + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_count = stat_q;
`endif

endmodule
